// File: rtl/dp_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_pkg
// Description : Shared types and default sizes for the dual-port data memory.
//               Holds the clear-sequencer state type and the default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;

    // CLEAR sweeps the array to zero, READY accepts accesses.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/dp_mem_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_clear_seq
// Description : Clear sequencer for dp_data_memory. Sweeps every address once
//               after reset or on clr_req and holds off accesses meanwhile.
//               Build option DP_MEM_CLEAR_EN enables the sweep; without it the
//               block only produces a ready flag one edge after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_mem_clear_seq
    import dp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_active,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

`ifdef DP_MEM_CLEAR_EN

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    // State and sweep counter registers; reset restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Sweep one address per edge; leave CLEAR on the edge that writes the last word.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                // Counter wraps naturally back to 0 on the last address.
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign clr_active = (r_state == CLEAR);
    assign clr_addr   = r_clr_cnt;
    assign ready      = (r_state == READY);

`else

    logic r_ready;
    logic w_unused_clr_req;

    // Without the sweep, ready simply follows the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_unused_clr_req = clr_req;
    assign clr_active       = 1'b0;
    assign clr_addr         = '0;
    assign ready            = r_ready;

`endif

endmodule
`default_nettype wire

// File: rtl/dp_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : dp_data_memory
// Description : Dual-port data memory. Port A is read/write (write-first on
//               its own address), port B is read-only (read-first against a
//               same-cycle port A write). Both ports have one-cycle registered
//               reads with valid pulses. Build option DP_MEM_CLEAR_EN adds a
//               clear sweep after reset and on clr_req.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_data_memory
    import dp_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_we,
    input  logic              a_re,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_re,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_clr_active;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_a_rd;
    logic              w_b_rd;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_rdata;
    logic              r_a_rvalid;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_b_rvalid;

    dp_mem_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_active (w_clr_active),
        .clr_addr   (w_clr_addr),
        .ready      (w_ready)
    );

    // The sweep owns the write port while active; reset itself never writes.
    assign w_wr_en   = rst_n & (w_clr_active | (w_ready & a_we));
    assign w_wr_addr = w_clr_active ? w_clr_addr : a_addr;
    assign w_wr_data = w_clr_active ? '0 : a_wdata;
    assign w_a_rd    = w_ready & a_re;
    assign w_b_rd    = w_ready & b_re;

    // Storage array, single write port shared by the sweep and port A.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Port A read register; a same-cycle write forwards the new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_rdata  <= '0;
            r_a_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_rd;
            if (w_a_rd) begin
                r_a_rdata <= a_we ? a_wdata : r_mem[a_addr];
            end
        end
    end

    // Port B read register; sees the array before any same-cycle port A write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_rdata  <= '0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_b_rvalid <= w_b_rd;
            if (w_b_rd) begin
                r_b_rdata <= r_mem[b_addr];
            end
        end
    end

    assign ready    = w_ready;
    assign a_rdata  = r_a_rdata;
    assign a_rvalid = r_a_rvalid;
    assign b_rdata  = r_b_rdata;
    assign b_rvalid = r_b_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dp_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_data_memory
// Description : Self-checking bench for dp_data_memory. With DP_MEM_CLEAR_EN
//               it runs DATA_W=16/ADDR_W=5 including the clear sweep; without
//               it runs DATA_W=8/ADDR_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_data_memory;

`ifdef DP_MEM_CLEAR_EN
    localparam int DW = 16;
    localparam int AW = 5;
`else
    localparam int DW = 8;
    localparam int AW = 3;
`endif
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          clr_req  = 1'b0;
    logic [AW-1:0] a_addr   = '0;
    logic [DW-1:0] a_wdata  = '0;
    logic          a_we     = 1'b0;
    logic          a_re     = 1'b0;
    logic [AW-1:0] b_addr   = '0;
    logic          b_re     = 1'b0;
    logic          ready;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] c_beef;
    logic [DW-1:0] c_1234;
    logic [DW-1:0] c_0a0a;
    logic [DW-1:0] c_5555;
    logic [DW-1:0] c_ones;

    dp_data_memory #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .clr_req  (clr_req),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_we     (a_we),
        .a_re     (a_re),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_addr   (b_addr),
        .b_re     (b_re),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_req = 1'b0;
        a_we    = 1'b0;
        a_re    = 1'b0;
        b_re    = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 200);
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] t;
        t = 32'(i) * 32'h0000_9E37 + 32'h0000_01B5;
        return t[DW-1:0];
    endfunction

    initial begin
        int n;
        int seen;
        c_beef = DW'(16'hBEEF);
        c_1234 = DW'(16'h1234);
        c_0a0a = DW'(16'h0A0A);
        c_5555 = DW'(16'h5555);
        c_ones = '1;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_ready",    32'(ready),    32'd0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_a_rdata",  32'(a_rdata),  32'd0);
        check("rst_b_rdata",  32'(b_rdata),  32'd0);

        rst_n = 1'b1;
        wait_ready(n);
`ifdef DP_MEM_CLEAR_EN
        check("init_ready_edges", 32'(n), 32'(DEPTH));
        // Fresh array must read all zeros on both ports, back to back.
        for (int i = 0; i < DEPTH; i++) begin
            a_re = 1'b1; a_addr = AW'(i);
            b_re = 1'b1; b_addr = AW'(DEPTH - 1 - i);
            tick();
            check("init_a_rvalid", 32'(a_rvalid), 32'd1);
            check("init_a_rdata",  32'(a_rdata),  32'd0);
            check("init_b_rvalid", 32'(b_rvalid), 32'd1);
            check("init_b_rdata",  32'(b_rdata),  32'd0);
        end
        idle();
        tick();
        check("init_a_rvalid_drop", 32'(a_rvalid), 32'd0);
        check("init_b_rvalid_drop", 32'(b_rvalid), 32'd0);
`else
        check("init_ready_edges", 32'(n), 32'd1);
`endif

        // ---------------- write then read 0xBEEF at address 7 ----------------
        a_we = 1'b1; a_addr = AW'(7); a_wdata = c_beef;
        tick();
        check("wr_no_rvalid", 32'(a_rvalid), 32'd0);
        a_we = 1'b0; a_re = 1'b1; b_re = 1'b1; b_addr = AW'(7);
        tick();
        check("beef_a_rvalid", 32'(a_rvalid), 32'd1);
        check("beef_a_rdata",  32'(a_rdata),  32'(c_beef));
        check("beef_b_rvalid", 32'(b_rvalid), 32'd1);
        check("beef_b_rdata",  32'(b_rdata),  32'(c_beef));
        idle();
        tick();
        check("hold_a_rvalid", 32'(a_rvalid), 32'd0);
        check("hold_a_rdata",  32'(a_rdata),  32'(c_beef));
        check("hold_b_rdata",  32'(b_rdata),  32'(c_beef));

        // ---------------- same-cycle collision at address 3 ----------------
        a_we = 1'b1; a_addr = AW'(3); a_wdata = c_beef;
        tick();
        a_we = 1'b1; a_re = 1'b1; a_addr = AW'(3); a_wdata = c_1234;
        b_re = 1'b1; b_addr = AW'(3);
        tick();
        check("coll_a_write_first", 32'(a_rdata), 32'(c_1234));
        check("coll_b_read_first",  32'(b_rdata), 32'(c_beef));
        idle();
        b_re = 1'b1; b_addr = AW'(3);
        tick();
        check("coll_b_after", 32'(b_rdata), 32'(c_1234));
        idle();

        // ---------------- fill all addresses, read back with wrap ----------------
        for (int i = 0; i < DEPTH; i++) begin
            a_we = 1'b1; a_addr = AW'(i); a_wdata = pat(i);
            tick();
        end
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            a_re = 1'b1; a_addr = AW'(DEPTH - 1 + k);
            b_re = 1'b1; b_addr = AW'(k);
            tick();
            check("fill_a_rdata", 32'(a_rdata), 32'(pat((DEPTH - 1 + k) % DEPTH)));
            check("fill_b_rdata", 32'(b_rdata), 32'(pat(k)));
        end
        idle();
        tick();

`ifdef DP_MEM_CLEAR_EN
        // ---------------- clr_req with accesses during the sweep ----------------
        for (int i = 0; i < DEPTH; i++) begin
            a_we = 1'b1; a_addr = AW'(i); a_wdata = c_ones;
            tick();
        end
        a_we = 1'b1; a_re = 1'b1; a_addr = AW'(5); a_wdata = c_0a0a;
        b_re = 1'b1; b_addr = AW'(5); clr_req = 1'b1;
        tick();
        check("clrreq_ready",       32'(ready),    32'd0);
        check("clrreq_a_performed", 32'(a_rvalid), 32'd1);
        check("clrreq_a_rdata",     32'(a_rdata),  32'(c_0a0a));
        check("clrreq_b_rdata",     32'(b_rdata),  32'(c_ones));
        clr_req = 1'b0;
        a_we = 1'b1; a_re = 1'b1; a_addr = '0; a_wdata = c_ones;
        b_re = 1'b1; b_addr = '0;
        seen = 0;
        n = 0;
        do begin
            tick();
            n++;
            clr_req = (n == 5);
            if (a_rvalid || b_rvalid) seen++;
        end while (!ready && n < 200);
        idle();
        check("clr_ready_edges", 32'(n),    32'(DEPTH));
        check("clr_no_rvalid",   32'(seen), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a_re = 1'b1; a_addr = AW'(i);
            b_re = 1'b1; b_addr = AW'(i);
            tick();
            check("clr_a_zero", 32'(a_rdata), 32'd0);
            check("clr_b_zero", 32'(b_rdata), 32'd0);
        end
        idle();

        // ---------------- reset in the middle of a sweep ----------------
        a_we = 1'b1; a_re = 1'b1; a_addr = AW'(9); a_wdata = c_5555;
        tick();
        check("pre_rst_a_rdata", 32'(a_rdata), 32'(c_5555));
        idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        a_re = 1'b1;
        tick();
        check("midrst_ready",    32'(ready),    32'd0);
        check("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("midrst_a_rdata",  32'(a_rdata),  32'd0);
        rst_n = 1'b1;
        wait_ready(n);
        check("midrst_ready_edges", 32'(n), 32'(DEPTH));
        a_re = 1'b1; a_addr = AW'(9);
        tick();
        check("midrst_addr9_zero", 32'(a_rdata), 32'd0);
        idle();
`else
        // ---------------- clr_req has no effect ----------------
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("noclr_ready", 32'(ready), 32'd1);
        a_re = 1'b1; a_addr = AW'(2);
        tick();
        check("noclr_a_rvalid", 32'(a_rvalid), 32'd1);
        check("noclr_a_rdata",  32'(a_rdata),  32'(pat(2)));
        idle();

        // ---------------- reset during operation ----------------
        rst_n = 1'b0;
        a_re = 1'b1;
        tick();
        check("rst2_ready",    32'(ready),    32'd0);
        check("rst2_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst2_a_rdata",  32'(a_rdata),  32'd0);
        check("rst2_b_rdata",  32'(b_rdata),  32'd0);
        idle();
        rst_n = 1'b1;
        wait_ready(n);
        check("rst2_ready_edges", 32'(n), 32'd1);
        a_we = 1'b1; a_addr = AW'(6); a_wdata = c_5555;
        tick();
        a_we = 1'b0; a_re = 1'b1; b_re = 1'b1; b_addr = AW'(6);
        tick();
        check("rst2_a_rdata_new", 32'(a_rdata), 32'(c_5555));
        check("rst2_b_rdata_new", 32'(b_rdata), 32'(c_5555));
        idle();
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
